// File: rtl/icache_direct_pkg.sv
// Shared definitions for the direct-mapped instruction cache.
//   - icache_state_t : refill controller states (IDLE / REFILL / DONE)
//   - off_bits / idx_bits / tag_bits : address-field widths derived from the
//     cache geometry (word offset, line index, tag)
package icache_direct_pkg;

    localparam int WORD_W = 32;

    typedef enum logic [1:0] {
        ICACHE_IDLE   = 2'd0,
        ICACHE_REFILL = 2'd1,
        ICACHE_DONE   = 2'd2
    } icache_state_t;

    function automatic int off_bits(input int words_per_line);
        return $clog2(words_per_line);
    endfunction

    function automatic int idx_bits(input int lines);
        return $clog2(lines);
    endfunction

    // Byte-offset bits [1:0] are never part of the tag.
    function automatic int tag_bits(input int lines, input int words_per_line);
        return WORD_W - $clog2(lines) - $clog2(words_per_line) - 2;
    endfunction

endpackage

// File: rtl/icache_direct_line_ram.sv
// Data and tag storage for the direct-mapped instruction cache.
// Ports:
//   clock                         write clock
//   data_we, write_index,
//   write_offset, write_data      one-word write into data[index][offset]
//   tag_we, write_tag             tag write for line write_index
//   read_index, read_offset       asynchronous lookup address
//   read_data, read_tag           word and tag of the looked-up line
// No reset: contents are meaningless until the matching valid bit is set.
module icache_direct_line_ram
    import icache_direct_pkg::*;
#(
    parameter int LINES          = 16,
    parameter int WORDS_PER_LINE = 4
) (
    input  logic                                        clock,
    input  logic                                        data_we,
    input  logic [idx_bits(LINES)-1:0]                  write_index,
    input  logic [off_bits(WORDS_PER_LINE)-1:0]         write_offset,
    input  logic [WORD_W-1:0]                           write_data,
    input  logic                                        tag_we,
    input  logic [tag_bits(LINES, WORDS_PER_LINE)-1:0]  write_tag,
    input  logic [idx_bits(LINES)-1:0]                  read_index,
    input  logic [off_bits(WORDS_PER_LINE)-1:0]         read_offset,
    output logic [WORD_W-1:0]                           read_data,
    output logic [tag_bits(LINES, WORDS_PER_LINE)-1:0]  read_tag
);

    localparam int TAGW = tag_bits(LINES, WORDS_PER_LINE);

    // Flat word array addressed by {index, offset}.
    logic [WORD_W-1:0] data_mem [LINES*WORDS_PER_LINE];
    logic [TAGW-1:0]   tag_mem  [LINES];

    always_ff @(posedge clock) begin
        if (data_we) begin
            data_mem[{write_index, write_offset}] <= write_data;
        end
        if (tag_we) begin
            tag_mem[write_index] <= write_tag;
        end
    end

    assign read_data = data_mem[{read_index, read_offset}];
    assign read_tag  = tag_mem[read_index];

endmodule

// File: rtl/icache_direct.sv
// Direct-mapped, read-only instruction cache between fetch and a word-wide
// backing memory. Hits return the instruction combinationally in the cycle
// pc_f is presented; a miss raises miss_stall and refills the whole line one
// word per mem_ack.
// Ports:
//   clock, reset     rising-edge clock, asynchronous active-high reset
//   pc_f             fetch PC (bits [1:0] ignored)
//   invalidate       one-cycle pulse dropping every valid bit
//   instruction_f    instruction for pc_f, 0 while miss_stall is high
//   miss_stall       high while pc_f is not yet available
//   mem_req/mem_addr word read request and word-aligned address
//   mem_ack/mem_rdata request accepted, read data valid this cycle
module icache_direct
    import icache_direct_pkg::*;
#(
    parameter int LINES          = 16,
    parameter int WORDS_PER_LINE = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] pc_f,
    input  logic        invalidate,
    output logic [31:0] instruction_f,
    output logic        miss_stall,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    localparam int OFF   = off_bits(WORDS_PER_LINE);
    localparam int IDX   = idx_bits(LINES);
    localparam int TAGW  = tag_bits(LINES, WORDS_PER_LINE);
    localparam int LINEW = IDX + TAGW;   // width of a line address (index + tag)

    localparam logic [OFF-1:0] LAST_WORD = {OFF{1'b1}};

    icache_state_t state, next_state;

    logic [LINES-1:0] valid;
    logic [LINEW-1:0] line_addr;        // line being refilled, {tag, index}
    logic [OFF-1:0]   counter;          // next word of the line to fetch
    logic             inv_pending;      // invalidate seen during a refill

    logic [OFF-1:0]   pc_offset;
    logic [IDX-1:0]   pc_index;
    logic [TAGW-1:0]  pc_tag;
    logic [IDX-1:0]   refill_index;
    logic [TAGW-1:0]  refill_tag;

    logic [31:0]      read_data;
    logic [TAGW-1:0]  read_tag;
    logic             hit;
    logic             start_miss;
    logic             fill_word;
    logic             fill_last;

    // Byte-select bits of the PC play no part in an instruction fetch.
    logic unused_pc_bits;
    assign unused_pc_bits = &{1'b0, pc_f[1:0]};

    assign pc_offset    = pc_f[OFF+1:2];
    assign pc_index     = pc_f[OFF+IDX+1:OFF+2];
    assign pc_tag       = pc_f[31:OFF+IDX+2];
    assign refill_index = line_addr[IDX-1:0];
    assign refill_tag   = line_addr[LINEW-1:IDX];

    icache_direct_line_ram #(
        .LINES          (LINES),
        .WORDS_PER_LINE (WORDS_PER_LINE)
    ) u_line_ram (
        .clock        (clock),
        .data_we      (fill_word),
        .write_index  (refill_index),
        .write_offset (counter),
        .write_data   (mem_rdata),
        .tag_we       (fill_last),
        .write_tag    (refill_tag),
        .read_index   (pc_index),
        .read_offset  (pc_offset),
        .read_data    (read_data),
        .read_tag     (read_tag)
    );

    // Lookups only count as hits in IDLE: during REFILL/DONE the line RAM may
    // be half written, and fetch must stay stalled until the controller is back.
    assign hit           = valid[pc_index] && (read_tag == pc_tag) && (state == ICACHE_IDLE);
    assign miss_stall    = !hit;
    assign instruction_f = hit ? read_data : 32'd0;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= ICACHE_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        mem_req    = 1'b0;
        mem_addr   = 32'd0;
        start_miss = 1'b0;
        fill_word  = 1'b0;
        fill_last  = 1'b0;
        case (state)
            ICACHE_IDLE: begin
                if (!hit) begin
                    start_miss = 1'b1;
                    next_state = ICACHE_REFILL;
                end
            end
            ICACHE_REFILL: begin
                // Address is a pure function of registered state, so it
                // holds steady for as long as memory withholds mem_ack.
                mem_req  = 1'b1;
                mem_addr = {line_addr, counter, 2'b00};
                if (mem_ack) begin
                    fill_word = 1'b1;
                    if (counter == LAST_WORD) begin
                        fill_last  = 1'b1;
                        next_state = ICACHE_DONE;
                    end
                end
            end
            ICACHE_DONE: begin
                next_state = ICACHE_IDLE;
            end
            default: begin
                next_state = ICACHE_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            valid       <= '0;
            line_addr   <= '0;
            counter     <= '0;
            inv_pending <= 1'b0;
        end else begin
            case (state)
                ICACHE_IDLE: begin
                    if (start_miss) begin
                        line_addr <= pc_f[31:OFF+2];
                        counter   <= '0;
                    end
                    // The victim line is dropped before its RAM is overwritten.
                    if (invalidate) begin
                        valid <= '0;
                    end else if (start_miss) begin
                        valid[pc_index] <= 1'b0;
                    end
                end
                ICACHE_REFILL: begin
                    if (invalidate) begin
                        inv_pending <= 1'b1;
                    end
                    if (fill_word) begin
                        counter <= counter + 1'b1;
                    end
                    // A line fetched across an invalidate may hold stale code,
                    // so it is never published.
                    if (fill_last && !inv_pending && !invalidate) begin
                        valid[refill_index] <= 1'b1;
                    end
                end
                ICACHE_DONE: begin
                    if (inv_pending || invalidate) begin
                        valid <= '0;
                    end
                    inv_pending <= 1'b0;
                end
                default: begin
                    inv_pending <= 1'b0;
                end
            endcase
        end
    end

endmodule
